csr_commit_unit: RTL and testbench

//  Executes committed CSR instructions. Sits downstream of the CSR address buffer, alongside the

---
 rtl/csr_commit_unit_pkg.sv | 28 ++
 rtl/csr_commit_unit_priv_check.sv | 12 +
 rtl/csr_commit_unit.sv | 129 ++++++++++++
 tb/tb_csr_commit_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_commit_unit_pkg.sv
// Shared types and constants for the CSR commit unit.
package csr_commit_unit_pkg;

  typedef enum logic [1:0] {
    CSR_RW = 2'b00,
    CSR_RS = 2'b01,
    CSR_RC = 2'b10,
    CSR_RD = 2'b11
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_WRITE,
    ST_DONE,
    ST_EXC
  } state_e;

  localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;

  // Writing any of these changes translation/status state the pipeline has already used.
  function automatic logic is_flush_csr(input logic [11:0] addr);
    return (addr == 12'h100) || (addr == 12'h180) ||
           (addr == 12'h300) || (addr == 12'h301);
  endfunction

endpackage

// File: rtl/csr_commit_unit_priv_check.sv
// Privilege and read-only access check for a committed CSR instruction.
module csr_commit_unit_priv_check (
  input  logic [3:0] addr_hi,
  input  logic [1:0] priv_lvl,
  input  logic       wr_int,
  output logic       illegal
);

  // addr[9:8] is the lowest privilege allowed; addr[11:10]==11 marks read-only.
  assign illegal = (priv_lvl < addr_hi[1:0]) || (wr_int && (addr_hi[3:2] == 2'b11));

endmodule

// File: rtl/csr_commit_unit.sv
// Executes committed CSR instructions: check, read-modify-write, result/exception/flush.
//
// state | meaning
// IDLE  | ready for a commit
// CHECK | privilege / read-only check on latched instruction
// READ  | request held until the register file answers
// WRITE | one-cycle write strobe
// DONE  | result pulse (plus flush request for side-effect CSRs)
// EXC   | illegal-instruction pulse
module csr_commit_unit
  import csr_commit_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            commit_valid_i,
  output logic            commit_ready_o,
  input  logic [11:0]     csr_addr_i,
  input  logic [1:0]      csr_op_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic            rs1_zero_i,
  input  logic            rd_zero_i,
  input  logic [1:0]      priv_lvl_i,
  output logic            rf_rreq_o,
  output logic [11:0]     rf_raddr_o,
  input  logic            rf_rvalid_i,
  input  logic [XLEN-1:0] rf_rdata_i,
  input  logic            rf_rerr_i,
  output logic            rf_we_o,
  output logic [11:0]     rf_waddr_o,
  output logic [XLEN-1:0] rf_wdata_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o,
  output logic            ex_valid_o,
  output logic            flush_req_o
);

  state_e          state_q, state_d;
  logic [11:0]     addr_q;
  csr_op_e         op_q;
  logic [XLEN-1:0] operand_q, old_q;
  logic            rs1_zero_q, rd_zero_q;
  logic            wr_int, rd_need, illegal, accept, capture;

  assign wr_int  = (op_q == CSR_RW) || (((op_q == CSR_RS) || (op_q == CSR_RC)) && !rs1_zero_q);
  assign rd_need = !((op_q == CSR_RW) && rd_zero_q);
  assign accept  = (state_q == ST_IDLE) && commit_valid_i && !flush_i;
  assign capture = (state_q == ST_READ) && rf_rvalid_i && !rf_rerr_i && !flush_i;

  csr_commit_unit_priv_check u_priv_check (
    .addr_hi  (addr_q[11:8]),
    .priv_lvl (priv_lvl_i),
    .wr_int   (wr_int),
    .illegal  (illegal)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      op_q       <= CSR_RW;
      operand_q  <= '0;
      rs1_zero_q <= 1'b0;
      rd_zero_q  <= 1'b0;
      old_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q     <= csr_addr_i;
        op_q       <= csr_op_e'(csr_op_i);
        operand_q  <= operand_i;
        rs1_zero_q <= rs1_zero_i;
        rd_zero_q  <= rd_zero_i;
        old_q      <= '0;
      end else if (capture) begin
        old_q <= rf_rdata_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_CHECK;
      ST_CHECK: begin
        if (flush_i)      state_d = ST_IDLE;
        else if (illegal) state_d = ST_EXC;
        else if (rd_need) state_d = ST_READ;
        else              state_d = ST_WRITE;
      end
      ST_READ: begin
        if (flush_i)          state_d = ST_IDLE;
        else if (rf_rvalid_i) begin
          if (rf_rerr_i)   state_d = ST_EXC;
          else if (wr_int) state_d = ST_WRITE;
          else             state_d = ST_DONE;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_EXC:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_wdata_o = operand_q;
    unique case (op_q)
      CSR_RW:  rf_wdata_o = operand_q;
      CSR_RS:  rf_wdata_o = old_q | operand_q;
      CSR_RC:  rf_wdata_o = old_q & ~operand_q;
      CSR_RD:  rf_wdata_o = old_q;
      default: rf_wdata_o = operand_q;
    endcase
  end

  assign commit_ready_o = (state_q == ST_IDLE);
  assign rf_rreq_o      = (state_q == ST_READ);
  assign rf_raddr_o     = addr_q;
  assign rf_we_o        = (state_q == ST_WRITE);
  assign rf_waddr_o     = addr_q;
  assign result_valid_o = (state_q == ST_DONE);
  assign result_o       = old_q;
  assign ex_valid_o     = (state_q == ST_EXC) && !flush_i;
  assign flush_req_o    = (state_q == ST_DONE) && wr_int && is_flush_csr(addr_q);

endmodule

// File: tb/tb_csr_commit_unit.sv
// Directed-vector bench for csr_commit_unit with hand-computed expectations.
module tb_csr_commit_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        commit_valid_i = 1'b0;
  logic        commit_ready_o;
  logic [11:0] csr_addr_i = '0;
  logic [1:0]  csr_op_i = '0;
  logic [63:0] operand_i = '0;
  logic        rs1_zero_i = 1'b0;
  logic        rd_zero_i = 1'b0;
  logic [1:0]  priv_lvl_i = 2'd3;
  logic        rf_rreq_o;
  logic [11:0] rf_raddr_o;
  logic        rf_rvalid_i = 1'b0;
  logic [63:0] rf_rdata_i = '0;
  logic        rf_rerr_i = 1'b0;
  logic        rf_we_o;
  logic [11:0] rf_waddr_o;
  logic [63:0] rf_wdata_o;
  logic        result_valid_o;
  logic [63:0] result_o;
  logic        ex_valid_o;
  logic        flush_req_o;

  csr_commit_unit #(.XLEN(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .commit_valid_i(commit_valid_i), .commit_ready_o(commit_ready_o),
    .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i), .operand_i(operand_i),
    .rs1_zero_i(rs1_zero_i), .rd_zero_i(rd_zero_i), .priv_lvl_i(priv_lvl_i),
    .rf_rreq_o(rf_rreq_o), .rf_raddr_o(rf_raddr_o), .rf_rvalid_i(rf_rvalid_i),
    .rf_rdata_i(rf_rdata_i), .rf_rerr_i(rf_rerr_i), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .result_valid_o(result_valid_o), .result_o(result_o),
    .ex_valid_o(ex_valid_o), .flush_req_o(flush_req_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  // observations from the last transaction
  logic        saw_rreq, saw_we, raddr_bad, waddr_bad, got_res, got_ex, got_flush, timed_out;
  logic [63:0] we_data, res_val;
  int          lat;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one commit and service the read port; rdata returned after wait_n request cycles.
  task automatic run_op(input logic [11:0] addr, input logic [1:0] op, input logic [63:0] opnd,
                        input logic rs1z, input logic rdz, input logic [1:0] priv,
                        input logic [63:0] rdata, input logic rerr, input int wait_n);
    int rcnt;
    saw_rreq = 0; saw_we = 0; raddr_bad = 0; waddr_bad = 0;
    got_res = 0; got_ex = 0; got_flush = 0; timed_out = 0;
    we_data = '0; res_val = '0; lat = 0; rcnt = 0;
    csr_addr_i = addr; csr_op_i = op; operand_i = opnd;
    rs1_zero_i = rs1z; rd_zero_i = rdz; priv_lvl_i = priv;
    rf_rdata_i = rdata; rf_rerr_i = rerr;
    commit_valid_i = 1'b1;
    step();
    commit_valid_i = 1'b0;
    lat = 1;
    while (!got_res && !got_ex) begin
      if (lat > 40) begin
        timed_out = 1;
        break;
      end
      rf_rvalid_i = 1'b0;
      if (rf_rreq_o) begin
        saw_rreq = 1;
        if (rf_raddr_o !== addr) raddr_bad = 1;
        if (rcnt == wait_n) rf_rvalid_i = 1'b1;
        rcnt++;
      end
      if (rf_we_o) begin
        saw_we = 1;
        we_data = rf_wdata_o;
        if (rf_waddr_o !== addr) waddr_bad = 1;
      end
      if (result_valid_o) begin
        got_res = 1; res_val = result_o; got_flush = flush_req_o;
      end
      if (ex_valid_o) got_ex = 1;
      if (!got_res && !got_ex) begin
        step();
        lat++;
      end
    end
    rf_rvalid_i = 1'b0;
    chk("timeout", {63'd0, timed_out}, 64'd0);
    step();
  endtask

  int strobes;

  initial begin
    #12;
    chk("rst_ready", {63'd0, commit_ready_o}, 64'd1);
    chk("rst_strobes", {60'd0, rf_rreq_o, rf_we_o, result_valid_o, ex_valid_o}, 64'd0);
    chk("rst_result", result_o, 64'd0);
    rst_ni = 1'b1;
    step();

    // M-mode RS mstatus, one wait cycle on read
    run_op(12'h300, 2'b01, 64'h8, 0, 0, 2'd3, 64'h1800, 0, 1);
    chk("rs_rreq", {63'd0, saw_rreq}, 64'd1);
    chk("rs_raddr_bad", {63'd0, raddr_bad}, 64'd0);
    chk("rs_we", {63'd0, saw_we}, 64'd1);
    chk("rs_wdata", we_data, 64'h1808);
    chk("rs_waddr_bad", {63'd0, waddr_bad}, 64'd0);
    chk("rs_result", res_val, 64'h1800);
    chk("rs_flushreq", {63'd0, got_flush}, 64'd1);
    chk("rs_lat", 64'(lat), 64'd5);

    // U-mode write to mstatus
    run_op(12'h300, 2'b00, 64'h1, 0, 0, 2'd0, 64'h0, 0, 0);
    chk("upriv_ex", {63'd0, got_ex}, 64'd1);
    chk("upriv_rreq", {63'd0, saw_rreq}, 64'd0);
    chk("upriv_we", {63'd0, saw_we}, 64'd0);

    // Write to read-only mhartid
    run_op(12'hF11, 2'b00, 64'h5, 0, 0, 2'd3, 64'h0, 0, 0);
    chk("ro_ex", {63'd0, got_ex}, 64'd1);
    chk("ro_we", {63'd0, saw_we}, 64'd0);

    // RS with rs1=x0 on read-only CSR is a pure read
    run_op(12'hF11, 2'b01, 64'h0, 1, 0, 2'd3, 64'h2A, 0, 0);
    chk("ro_rd_ex", {63'd0, got_ex}, 64'd0);
    chk("ro_rd_result", res_val, 64'h2A);
    chk("ro_rd_we", {63'd0, saw_we}, 64'd0);
    chk("ro_rd_lat", 64'(lat), 64'd3);

    // RW mtvec... 0x340 mscratch with rd=x0: no read
    run_op(12'h340, 2'b00, 64'hAB, 0, 1, 2'd3, 64'hFFFF, 0, 0);
    chk("rw0_rreq", {63'd0, saw_rreq}, 64'd0);
    chk("rw0_wdata", we_data, 64'hAB);
    chk("rw0_result", res_val, 64'h0);
    chk("rw0_flushreq", {63'd0, got_flush}, 64'd0);
    chk("rw0_lat", 64'(lat), 64'd3);

    // Read of nonexistent CSR
    run_op(12'h7C0, 2'b11, 64'h0, 1, 0, 2'd3, 64'h0, 1, 2);
    chk("rerr_ex", {63'd0, got_ex}, 64'd1);
    chk("rerr_we", {63'd0, saw_we}, 64'd0);

    // S-mode RC sscratch: legal, no flush request
    run_op(12'h140, 2'b10, 64'h0F, 0, 0, 2'd1, 64'hFF, 0, 0);
    chk("rc_wdata", we_data, 64'hF0);
    chk("rc_result", res_val, 64'hFF);
    chk("rc_flushreq", {63'd0, got_flush}, 64'd0);
    chk("rc_lat", 64'(lat), 64'd4);

    // S-mode read of M-mode CSR
    run_op(12'h300, 2'b11, 64'h0, 1, 0, 2'd1, 64'h0, 0, 0);
    chk("spriv_ex", {63'd0, got_ex}, 64'd1);

    // flush with commit_valid in IDLE: not accepted
    csr_addr_i = 12'h340; csr_op_i = 2'b00; rd_zero_i = 1'b1; priv_lvl_i = 2'd3;
    flush_i = 1'b1; commit_valid_i = 1'b1;
    step();
    flush_i = 1'b0; commit_valid_i = 1'b0;
    chk("idle_flush_ready", {63'd0, commit_ready_o}, 64'd1);
    strobes = 0;
    for (int i = 0; i < 4; i++) begin
      if (rf_we_o || result_valid_o) strobes++;
      step();
    end
    chk("idle_flush_strobes", 64'(strobes), 64'd0);

    // flush during a long read
    csr_addr_i = 12'h300; csr_op_i = 2'b01; operand_i = 64'h8;
    rs1_zero_i = 1'b0; rd_zero_i = 1'b0; rf_rerr_i = 1'b0; rf_rdata_i = 64'h55;
    commit_valid_i = 1'b1;
    step();
    commit_valid_i = 1'b0;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      if (rf_we_o || result_valid_o || ex_valid_o) strobes++;
      step();
    end
    chk("fl_in_read", {63'd0, rf_rreq_o}, 64'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("fl_ready", {63'd0, commit_ready_o}, 64'd1);
    chk("fl_rreq", {63'd0, rf_rreq_o}, 64'd0);
    rf_rvalid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rf_we_o || result_valid_o || ex_valid_o || !commit_ready_o) strobes++;
      step();
    end
    rf_rvalid_i = 1'b0;
    chk("fl_strobes", 64'(strobes), 64'd0);

    // next commit after flush works normally
    run_op(12'h300, 2'b10, 64'h800, 0, 0, 2'd3, 64'h1808, 0, 0);
    chk("post_wdata", we_data, 64'h1008);
    chk("post_result", res_val, 64'h1808);
    chk("post_flushreq", {63'd0, got_flush}, 64'd1);
    chk("post_lat", 64'(lat), 64'd4);

    // reset mid-operation
    csr_addr_i = 12'h340; csr_op_i = 2'b00; operand_i = 64'h1; rd_zero_i = 1'b1;
    commit_valid_i = 1'b1;
    step();
    commit_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("midrst_ready", {63'd0, commit_ready_o}, 64'd1);
    chk("midrst_we", {63'd0, rf_we_o}, 64'd0);
    step();
    rst_ni = 1'b1;
    strobes = 0;
    for (int i = 0; i < 3; i++) begin
      if (rf_we_o || result_valid_o) strobes++;
      step();
    end
    chk("midrst_strobes", 64'(strobes), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
